player_keys: RTL and testbench

Input conditioner for the two player pushbuttons in the tug-of-war light chain. It synchronizes and debounces the raw active-low board keys. For each debounced press it emits exactly one single-cycle, active-high pulse on `L` or `R`. These pulses drive the `L`/`R` inputs of every light cell in the chain. Gating by `enable` lets the game controller freeze input once a winner is declared.

---
 rtl/player_keys_pkg.sv | 5 +
 rtl/player_keys_if.sv | 10 +
 rtl/key_channel.sv | 75 +++++++
 rtl/player_keys.sv | 23 ++
 tb/tb_player_keys.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/player_keys_pkg.sv
// player_keys_pkg: shared key-channel state type and constants
package player_keys_pkg;
    typedef enum logic [1:0] {K_IDLE, K_PRESS, K_HELD, K_RELEASE} kstate_t;
    localparam logic KEY_RELEASED = 1'b1;
endpackage

// File: rtl/player_keys_if.sv
// player_keys_if: raw keys and enable in, move pulses out
interface player_keys_if;
    logic key_l_n;
    logic key_r_n;
    logic enable;
    logic L;
    logic R;
    modport master (output key_l_n, key_r_n, enable, input L, R);
    modport slave (input key_l_n, key_r_n, enable, output L, R);
endinterface

// File: rtl/key_channel.sv
// key_channel: synchronize, debounce and pulse one active-low pushbutton
module key_channel
    import player_keys_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    input  logic enable,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    kstate_t st;
    logic s;
    logic done;
    assign s = ~sync[1];
    assign done = (cnt + ONE) == LAST;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= {2{KEY_RELEASED}};
            st <= K_IDLE;
            cnt <= '0;
            pulse <= 1'b0;
        end else begin
            sync <= {sync[0], key_n};
            pulse <= 1'b0;
            case (st)
                K_IDLE:
                    if (s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            st <= K_HELD;
                            pulse <= enable;
                        end else begin
                            st <= K_PRESS;
                            cnt <= ONE;
                        end
                    end
                K_PRESS:
                    if (!s) begin
                        st <= K_IDLE;
                        cnt <= '0;
                    end else if (done) begin
                        st <= K_HELD;
                        cnt <= '0;
                        pulse <= enable;
                    end else
                        cnt <= cnt + ONE;
                K_HELD:
                    if (!s) begin
                        st <= (DEBOUNCE_CYCLES == 1) ? K_IDLE : K_RELEASE;
                        cnt <= (DEBOUNCE_CYCLES == 1) ? '0 : ONE;
                    end
                K_RELEASE:
                    // a high sample during release is bounce: back to held, never a new press
                    if (s) begin
                        st <= K_HELD;
                        cnt <= '0;
                    end else if (done) begin
                        st <= K_IDLE;
                        cnt <= '0;
                    end else
                        cnt <= cnt + ONE;
                default: begin
                    st <= K_IDLE;
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: rtl/player_keys.sv
// player_keys: two independent debounced key channels producing L/R move pulses
module player_keys #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic clk,
    input logic reset,
    player_keys_if.slave io
);
    key_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk(clk),
        .reset(reset),
        .key_n(io.key_l_n),
        .enable(io.enable),
        .pulse(io.L)
    );
    key_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk(clk),
        .reset(reset),
        .key_n(io.key_r_n),
        .enable(io.enable),
        .pulse(io.R)
    );
endmodule

// File: tb/tb_player_keys.sv
// tb_player_keys: directed and random key stimulus against a run-length debounce model
module tb_player_keys;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic kl = 1'b1;
    logic kr = 1'b1;
    logic en = 1'b1;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nl, nr, nlb, last_l, last_r, last_lb;
    int dd[4] = '{4, 4, 1, 1};
    bit lvl[4];
    int run[4];
    bit [1:0] pipe[4];
    bit expv[4];

    always #5 clk = ~clk;

    player_keys_if ia();
    player_keys_if ib();
    assign ia.key_l_n = kl;
    assign ia.key_r_n = kr;
    assign ia.enable = en;
    assign ib.key_l_n = kl;
    assign ib.key_r_n = kr;
    assign ib.enable = en;

    player_keys #(.DEBOUNCE_CYCLES(4)) dut_a (.clk(clk), .reset(reset), .io(ia));
    player_keys #(.DEBOUNCE_CYCLES(1)) dut_b (.clk(clk), .reset(reset), .io(ib));

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Debounced level flips once D consecutive pressed-signal samples disagree with it
    task automatic model_edge();
        for (int c = 0; c < 4; c++) begin
            bit s;
            bit r;
            r = (c % 2 == 0) ? kl : kr;
            if (reset) begin
                pipe[c] = 2'b11;
                lvl[c] = 1'b0;
                run[c] = 0;
                expv[c] = 1'b0;
            end else begin
                s = ~pipe[c][1];
                pipe[c] = {pipe[c][0], r};
                expv[c] = 1'b0;
                if (s != lvl[c]) begin
                    run[c]++;
                    if (run[c] == dd[c]) begin
                        lvl[c] = s;
                        run[c] = 0;
                        if (s) expv[c] = en;
                    end
                end else
                    run[c] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        check("a_L", int'(ia.L), int'(expv[0]));
        check("a_R", int'(ia.R), int'(expv[1]));
        check("b_L", int'(ib.L), int'(expv[2]));
        check("b_R", int'(ib.R), int'(expv[3]));
        if (ia.L) begin nl++; last_l = cyc; end
        if (ia.R) begin nr++; last_r = cyc; end
        if (ib.L) begin nlb++; last_lb = cyc; end
    endtask

    task automatic mark();
        cyc = -1;
        nl = 0; nr = 0; nlb = 0;
        last_l = -1; last_r = -1; last_lb = -1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bit [6:0] bounce_on;
        bit [6:0] bounce_off;
        bounce_on = 7'b0010000;
        bounce_off = 7'b1011111;
        @(negedge clk);
        reset = 1'b1; kl = 1'b0; kr = 1'b0;
        mark();
        ticks(2);
        check("rst_quiet", nl + nr, 0);
        reset = 1'b0;
        mark();
        ticks(8);
        check("rst_l_n", nl, 1);
        check("rst_l_t", last_l, 5);
        check("rst_r_t", last_r, 5);
        kl = 1'b1; kr = 1'b1;
        ticks(10);

        mark(); kl = 1'b0;
        ticks(20);
        check("clean_n", nl, 1);
        check("clean_t", last_l, 5);
        check("clean_r", nr, 0);
        check("d1_t", last_lb, 2);
        kl = 1'b1;
        ticks(10);

        mark();
        for (int i = 0; i < 7; i++) begin
            kr = bounce_on[6-i];
            tick();
        end
        ticks(10);
        check("bounce_t", last_r, 8);
        for (int i = 0; i < 7; i++) begin
            kr = bounce_off[6-i];
            tick();
        end
        ticks(10);
        check("bounce_n", nr, 1);

        mark(); kl = 1'b0; kr = 1'b0;
        ticks(12);
        check("sim_l", last_l, 5);
        check("sim_r", last_r, 5);
        kl = 1'b1; kr = 1'b1;
        ticks(10);

        mark(); en = 1'b0; kl = 1'b0;
        ticks(10);
        en = 1'b1;
        ticks(10);
        check("en_late", nl + nlb, 0);
        kl = 1'b1;
        ticks(6);
        mark(); kl = 1'b0;
        ticks(10);
        check("en_again", nl, 1);
        kl = 1'b1;
        ticks(10);

        mark(); kl = 1'b0;
        ticks(3);
        reset = 1'b1; kl = 1'b1;
        ticks(2);
        reset = 1'b0;
        ticks(10);
        check("rst_mid", nl, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 5 == 0) kl = ~kl;
            if ($urandom % 5 == 0) kr = ~kr;
            if ($urandom % 40 == 0) en = ~en;
            reset = ($urandom % 200 == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
